gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 81 ++++++++
 tb/tb_gray_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code mirror, synchronous load and a boundary pulse.
// Define GRAY_COUNTER_SATURATE_EN to hold at the end values instead of wrapping.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ {1'b0, b[WIDTH-1:1]};
    endfunction

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gry_q, gry_d;
    logic             wrap_q, wrap_d;
    logic             boundary_s;

    // Next-state selection: load beats step, step beats hold.
    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        boundary_s = 1'b0;
        if (load) begin
            cnt_d  = load_val;
            wrap_d = 1'b0;
        end else if (en) begin
            boundary_s = up_dn ? (cnt_q == MAX_C) : (cnt_q == ZERO_C);
            wrap_d     = boundary_s;
`ifdef GRAY_COUNTER_SATURATE_EN
            if (boundary_s) begin
                cnt_d = cnt_q;
            end else if (up_dn) begin
                cnt_d = cnt_q + ONE_C;
            end else begin
                cnt_d = cnt_q - ONE_C;
            end
`else
            if (up_dn) begin
                cnt_d = cnt_q + ONE_C;
            end else begin
                cnt_d = cnt_q - ONE_C;
            end
`endif
        end else begin
            cnt_d  = cnt_q;
            wrap_d = 1'b0;
        end
        // Gray is derived from the next binary value so both registers update together.
        gry_d = bin2gray(cnt_d);
    end

    // Counter, Gray mirror and wrap pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= ZERO_C;
            gry_q  <= ZERO_C;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gry_q  <= gry_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_q  = cnt_q;
    assign gray_q = gry_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4) against an arithmetic reference model.
module tb_gray_counter;

    localparam int W    = 4;
    localparam int MODV = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic         wrap;

    int n_checks;
    int n_fail;
    int m_val;
    bit m_wrap;
    bit m_moved;

    gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .bin_q    (bin_q),
        .gray_q   (gray_q),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray code built bit by bit from its definition.
    function automatic logic [W-1:0] gray_of(input int b);
        logic [W-1:0] bv;
        logic [W-1:0] g;
        bv = W'(b);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) g[i] = bv[i];
            else            g[i] = bv[i+1] ^ bv[i];
        end
        return g;
    endfunction

    function automatic int bits_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample 1ns later.
    task automatic drive_cycle(input bit l, input bit e, input bit u, input logic [W-1:0] lv);
        int nxt;
        load = l; en = e; up_dn = u; load_val = lv;
        @(posedge clk);
        nxt = m_val;
        if (l) begin
            nxt = int'(lv);
            m_wrap = 1'b0;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_val == MODV - 1);
                nxt = (m_val + 1) % MODV;
            end else begin
                m_wrap = (m_val == 0);
                nxt = (m_val + MODV - 1) % MODV;
            end
`ifdef GRAY_COUNTER_SATURATE_EN
            if (m_wrap) nxt = m_val;
`endif
        end else begin
            m_wrap = 1'b0;
        end
        m_moved = (nxt != m_val) && !l;
        m_val = nxt;
        #1;
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bin_q !== 4'h0) begin n_fail++; $display("FAIL reset_bin: got %h want 0", bin_q); end
        n_checks++; if (gray_q !== 4'h0) begin n_fail++; $display("FAIL reset_gray: got %b want 0000", gray_q); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        @(negedge clk);
        rst_n = 1'b1;
        m_val = 0; m_wrap = 1'b0;
    endtask

    task automatic test_count_up();
        logic [W-1:0] prev;
        for (int i = 0; i < 16; i++) begin
            prev = gray_q;
            drive_cycle(1'b0, 1'b1, 1'b1, 4'h0);
            n_checks++; if (bin_q !== W'(m_val)) begin n_fail++; $display("FAIL up_bin[%0d]: got %h want %h", i, bin_q, W'(m_val)); end
            n_checks++; if (gray_q !== gray_of(m_val)) begin n_fail++; $display("FAIL up_gray[%0d]: got %b want %b", i, gray_q, gray_of(m_val)); end
            n_checks++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap, m_wrap); end
            if (m_moved) begin
                n_checks++; if (bits_diff(prev, gray_q) != 1) begin n_fail++; $display("FAIL up_onebit[%0d]: got %0d bits want 1", i, bits_diff(prev, gray_q)); end
            end
        end
    endtask

    task automatic test_load_priority();
        drive_cycle(1'b1, 1'b1, 1'b1, 4'hA);
        n_checks++; if (bin_q !== 4'hA) begin n_fail++; $display("FAIL load_bin: got %h want a", bin_q); end
        n_checks++; if (gray_q !== 4'b1111) begin n_fail++; $display("FAIL load_gray: got %b want 1111", gray_q); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_wrap: got %b want 0", wrap); end
        drive_cycle(1'b1, 1'b1, 1'b0, 4'hF);
        drive_cycle(1'b1, 1'b1, 1'b1, 4'h3);
        n_checks++; if (wrap !== 1'b0 || bin_q !== 4'h3) begin n_fail++; $display("FAIL load_over_wrap: got %h/%b want 3/0", bin_q, wrap); end
    endtask

    task automatic test_down_wrap();
        drive_cycle(1'b1, 1'b0, 1'b0, 4'h0);
        drive_cycle(1'b0, 1'b1, 1'b0, 4'h0);
        n_checks++; if (bin_q !== W'(m_val)) begin n_fail++; $display("FAIL down_bin: got %h want %h", bin_q, W'(m_val)); end
        n_checks++; if (gray_q !== gray_of(m_val)) begin n_fail++; $display("FAIL down_gray: got %b want %b", gray_q, gray_of(m_val)); end
        n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL down_wrap: got %b want 1", wrap); end
        drive_cycle(1'b0, 1'b0, 1'b0, 4'h0);
        n_checks++; if (wrap !== 1'b0 || bin_q !== W'(m_val)) begin n_fail++; $display("FAIL hold: got %h/%b want %h/0", bin_q, wrap, W'(m_val)); end
    endtask

    task automatic test_alternate();
        logic [W-1:0] exp_b [3];
        logic [W-1:0] exp_g [3];
        exp_b[0] = 4'h8; exp_b[1] = 4'h7; exp_b[2] = 4'h8;
        exp_g[0] = 4'b1100; exp_g[1] = 4'b0100; exp_g[2] = 4'b1100;
        drive_cycle(1'b1, 1'b0, 1'b0, 4'h7);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, (i != 1), 4'h0);
            n_checks++; if (bin_q !== exp_b[i]) begin n_fail++; $display("FAIL alt_bin[%0d]: got %h want %h", i, bin_q, exp_b[i]); end
            n_checks++; if (gray_q !== exp_g[i]) begin n_fail++; $display("FAIL alt_gray[%0d]: got %b want %b", i, gray_q, exp_g[i]); end
            n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL alt_wrap[%0d]: got %b want 0", i, wrap); end
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b1, 4'h0);
        n_checks++; if (bin_q !== 4'h5) begin n_fail++; $display("FAIL pre_rst_bin: got %h want 5", bin_q); end
        load = 1'b1; load_val = 4'hC; en = 1'b1; up_dn = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bin_q !== 4'h0 || gray_q !== 4'h0 || wrap !== 1'b0) begin n_fail++; $display("FAIL async_rst: got %h/%b/%b want 0/0000/0", bin_q, gray_q, wrap); end
        @(posedge clk);
        #1;
        n_checks++; if (bin_q !== 4'h0 || gray_q !== 4'h0 || wrap !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %h/%b/%b want 0/0000/0", bin_q, gray_q, wrap); end
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        rst_n = 1'b1;
        m_val = 0; m_wrap = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b1, 4'h0);
        n_checks++; if (bin_q !== 4'h1) begin n_fail++; $display("FAIL post_rst_step: got %h want 1", bin_q); end
    endtask

    task automatic test_random();
        logic [W-1:0] prev;
        bit l, e, u;
        for (int i = 0; i < 10000; i++) begin
            prev = gray_q;
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = $urandom_range(0, 1);
            drive_cycle(l, e, u, W'($urandom));
            n_checks++; if (bin_q !== W'(m_val) || gray_q !== gray_of(m_val) || wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL rnd[%0d]: got %h/%b/%b want %h/%b/%b", i, bin_q, gray_q, wrap, W'(m_val), gray_of(m_val), m_wrap);
            end
            if (m_moved) begin
                n_checks++; if (bits_diff(prev, gray_q) != 1) begin n_fail++; $display("FAIL rnd_onebit[%0d]: got %0d bits want 1", i, bits_diff(prev, gray_q)); end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_val = 0; m_wrap = 1'b0; m_moved = 1'b0;
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
        test_reset();
        test_count_up();
        test_load_priority();
        test_down_wrap();
        test_alternate();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
